// File: rtl/dual_port_ram.sv
// True dual-port RAM on one clock; define DUAL_PORT_RAM_RESET_CLEAR_EN to zero all words on reset.
// Latency: one cycle, registered read; write-first on the same port, old data across ports.
// Backpressure: none; both ports accept an access every cycle.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic                  a_write_enable,
    output logic [DATA_WIDTH-1:0] a_read,
    input  logic [DATA_WIDTH-1:0] b_data,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic                  b_write_enable,
    output logic [DATA_WIDTH-1:0] b_read
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Port A's write is issued last so it wins a same-address double write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_read <= '0;
            b_read <= '0;
`ifdef DUAL_PORT_RAM_RESET_CLEAR_EN
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
`else
`endif
        end else begin
            if (b_write_enable) begin
                mem[b_addr] <= b_data;
                b_read      <= b_data;
            end else begin
                b_read      <= mem[b_addr];
            end
            if (a_write_enable) begin
                mem[a_addr] <= a_data;
                a_read      <= a_data;
            end else begin
                a_read      <= mem[a_addr];
            end
        end
    end

endmodule

// File: tb/tb_dual_port_ram.sv
// Bench for dual_port_ram: vector table plus hand sequences, checked through an expectation queue.
module tb_dual_port_ram;

    localparam int DW = 8;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] a_data = '0;
    logic [AW-1:0] a_addr = '0;
    logic          a_write_enable = 1'b0;
    logic [DW-1:0] a_read;
    logic [DW-1:0] b_data = '0;
    logic [AW-1:0] b_addr = '0;
    logic          b_write_enable = 1'b0;
    logic [DW-1:0] b_read;

    dual_port_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk            (clk),
        .rst            (rst),
        .a_data         (a_data),
        .a_addr         (a_addr),
        .a_write_enable (a_write_enable),
        .a_read         (a_read),
        .b_data         (b_data),
        .b_addr         (b_addr),
        .b_write_enable (b_write_enable),
        .b_read         (b_read)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_data;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_data;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    typedef struct {
        int            tag;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } exp_t;

    vec_t    vecs[$];
    exp_t    sb[$];
    int      n_checks = 0;
    int      n_pass   = 0;
    logic [DW-1:0] model [2**AW];

`ifdef DUAL_PORT_RAM_RESET_CLEAR_EN
    localparam logic [DW-1:0] KEEP01 = 8'h00;
    localparam logic [DW-1:0] KEEP03 = 8'h00;
    localparam logic [DW-1:0] KEEP3F = 8'h00;
`else
    localparam logic [DW-1:0] KEEP01 = 8'h33;
    localparam logic [DW-1:0] KEEP03 = 8'h55;
    localparam logic [DW-1:0] KEEP3F = 8'hA5;
`endif

    task automatic add_vec(input logic r, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                           input logic bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                           input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        vec_t v;
        v.rst = r; v.a_we = aw; v.a_addr = aa; v.a_data = ad;
        v.b_we = bw; v.b_addr = ba; v.b_data = bd; v.exp_a = ea; v.exp_b = eb;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int tag, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s tag=%0d actual=0x%02h required=0x%02h", name, tag, act, req);
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic cycle(input int tag, input logic r, input logic aw, input logic [AW-1:0] aa,
                         input logic [DW-1:0] ad, input logic bw, input logic [AW-1:0] ba,
                         input logic [DW-1:0] bd, input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        exp_t e;
        rst = r; a_write_enable = aw; a_addr = aa; a_data = ad;
        b_write_enable = bw; b_addr = ba; b_data = bd;
        e.tag = tag; e.exp_a = ea; e.exp_b = eb;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", tag, 8'h01, 8'h00);
        end else begin
            e = sb.pop_front();
            check("a_read", e.tag, a_read, e.exp_a);
            check("b_read", e.tag, b_read, e.exp_b);
        end
    endtask

    initial begin
        //        rst a_we a_addr a_data b_we b_addr b_data exp_a  exp_b
        add_vec(1, 0, 6'h00, 8'h00, 0, 6'h00, 8'h00, 8'h00, 8'h00);
        add_vec(0, 1, 6'h01, 8'h33, 1, 6'h02, 8'h44, 8'h33, 8'h44);
        add_vec(0, 0, 6'h02, 8'h00, 0, 6'h01, 8'h00, 8'h44, 8'h33);
        add_vec(0, 1, 6'h03, 8'h55, 0, 6'h01, 8'h00, 8'h55, 8'h33);
        add_vec(0, 0, 6'h03, 8'h00, 0, 6'h02, 8'h00, 8'h55, 8'h44);
        add_vec(0, 0, 6'h02, 8'h00, 1, 6'h02, 8'h77, 8'h44, 8'h77);
        add_vec(0, 0, 6'h02, 8'h00, 0, 6'h02, 8'h00, 8'h77, 8'h77);
        add_vec(0, 1, 6'h10, 8'hAA, 1, 6'h10, 8'hBB, 8'hAA, 8'hBB);
        add_vec(0, 0, 6'h10, 8'h00, 0, 6'h10, 8'h00, 8'hAA, 8'hAA);
        add_vec(1, 1, 6'h01, 8'h99, 1, 6'h03, 8'h11, 8'h00, 8'h00);
        add_vec(0, 0, 6'h01, 8'h00, 0, 6'h03, 8'h00, KEEP01, KEEP03);
        add_vec(0, 1, 6'h00, 8'h5A, 1, 6'h3F, 8'hA5, 8'h5A, 8'hA5);
        add_vec(0, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'hA5, 8'h5A);
        add_vec(0, 0, 6'h00, 8'h00, 0, 6'h3F, 8'h00, 8'h5A, 8'hA5);
        add_vec(0, 1, 6'h00, 8'h66, 0, 6'h00, 8'h00, 8'h66, 8'h5A);
        add_vec(0, 0, 6'h3F, 8'h00, 0, 6'h00, 8'h00, 8'hA5, 8'h66);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(i, vecs[i].rst, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_data,
                  vecs[i].b_we, vecs[i].b_addr, vecs[i].b_data, vecs[i].exp_a, vecs[i].exp_b);
        end

        // Reset held over several edges with writes presented: outputs stay zero, writes dropped.
        for (int i = 0; i < 3; i++) begin
            cycle(100 + i, 1'b1, 1'b1, 6'h3F, 8'hFF, 1'b1, 6'h3F, 8'hEE, 8'h00, 8'h00);
        end
        cycle(103, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b0, 6'h3F, 8'h00, KEEP3F, KEEP3F);

        // Full sweep: fill every word from both ports at once, then read back crosswise.
        for (int i = 0; i < 32; i++) begin
            logic [DW-1:0] da, db;
            da = DW'(i * 7 + 3);
            db = DW'(8'hC0 ^ (i * 5));
            model[i]      = da;
            model[i + 32] = db;
            cycle(200 + i, 1'b0, 1'b1, AW'(i), da, 1'b1, AW'(i + 32), db, da, db);
        end
        for (int j = 0; j < 64; j++) begin
            cycle(300 + j, 1'b0, 1'b0, AW'(j), 8'h00, 1'b0, AW'(63 - j), 8'h00,
                  model[j], model[63 - j]);
        end

        if (sb.size() != 0) check("scoreboard_leftover", 999, DW'(sb.size()), 8'h00);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dual_port_ram.md
DUAL_PORT_RAM -- requirements
Module: dual_port_ram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width; depth = 2**ADDR_WIDTH (64 words).
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous, active-high.
REQ-005 SHALL have port a_data, input, DATA_WIDTH, port A write data.
REQ-006 SHALL have port a_addr, input, ADDR_WIDTH, port A address.
REQ-007 SHALL have port a_write_enable, input, 1, port A write strobe (1 = write, 0 = read).
REQ-008 SHALL have port a_read, output, DATA_WIDTH, port A registered read data.
REQ-009 SHALL have port b_data, input, DATA_WIDTH, port B write data.
REQ-010 SHALL have port b_addr, input, ADDR_WIDTH, port B address.
REQ-011 SHALL have port b_write_enable, input, 1, port B write strobe.
REQ-012 SHALL have port b_read, output, DATA_WIDTH, port B registered read data.

Function
REQ-013 SHALL store 2**ADDR_WIDTH words shared by both ports; both ports are fully independent and operate every cycle, with no enable and no handshake.
REQ-014 SHALL, on each rising edge with x_write_enable=1, write x_data to mem[x_addr].
REQ-015 SHALL, on each rising edge with x_write_enable=0, load x_read with mem[x_addr]; latency is one cycle and the output holds until the next edge.
REQ-016 SHALL, on a port write, also load x_read with x_data (write-first on the same port).
REQ-017 SHALL, when one port reads an address the other port writes in the same cycle, return the old stored word (read-before-write across ports); the new word is visible from the next cycle.
REQ-018 SHALL, when both ports write the same address in the same cycle, store port A's data; each port's x_read shows its own x_data.
REQ-019 SHALL have no address wrap or out-of-range case; every ADDR_WIDTH value is a valid location.

Reset
REQ-020 SHALL, while rst=1 at a rising edge, clear a_read and b_read to 0 and ignore both write strobes.
REQ-021 SHALL, with rst asserted mid-operation, abort any write presented in that cycle; writes completed on earlier edges persist (unless REQ-023 applies).
REQ-022 SHALL resume normal operation on the first rising edge after rst deasserts.

Configuration
REQ-023 SHALL, with macro DUAL_PORT_RAM_RESET_CLEAR_EN defined, zero all memory words on every reset edge in addition to REQ-020.
REQ-024 SHALL, without DUAL_PORT_RAM_RESET_CLEAR_EN, leave memory contents untouched by reset; unwritten words are undefined.

Verification
REQ-025 SHALL cover dual write/read-back: A writes 0x33@0x01 and B writes 0x44@0x02; then A reads 0x02 and B reads 0x01 -> a_read=0x44 and b_read=0x33 one edge later.
REQ-026 SHALL cover write-first: A writes 0x55@0x03 -> a_read=0x55 after that edge; a following A read of 0x03 -> 0x55.
REQ-027 SHALL cover cross-port collision: B writes 0x77@0x02 while A reads 0x02 (holding 0x44) -> a_read=0x44 that cycle, and 0x77 on the next read.
REQ-028 SHALL cover a same-address double write: A writes 0xAA and B writes 0xBB @0x10 -> a later read of 0x10 returns 0xAA.
REQ-029 SHALL cover reset mid-operation: rst=1 with A writing 0x99@0x01 -> a_read=b_read=0; a read of 0x01 returns 0x33 without the macro and 0x00 with DUAL_PORT_RAM_RESET_CLEAR_EN.
REQ-030 SHALL cover boundary addresses: write 0x5A@0x00 and 0xA5@0x3F -> both read back correctly on either port.
